icache_refill_ctrl: RTL and testbench
=====================================

Name: icache_refill_ctrl

Overview:
- Miss/refill sequencer between the two-stage instruction cache and the AXI read channel.
- On a miss (cached) it fetches one 8-word line with a single INCR burst. On an uncached fetch it does a single-beat read.
- It assembles the returned beats into a 256-bit line and pulses rend_o with the line on the same cycle, which is the contract the cache's RAM-install logic expects.
- One transaction is outstanding at a time.

Parameters:
- AXI_ID, 4'd0, fixed arid driven on every request.
- BLOCK_NUM, 8, 32-bit words per cache line; line width = 32*BLOCK_NUM.

Ports:
- clk  in  1  system clock, single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- req_i  in  1  fetch request (miss or uncached) from cache stage 2
- cached_i  in  1  1 = cached line refill, 0 = uncached single word
- paddr_i  in  32  physical fetch address
- busy_o  out  1  transaction in progress (high in AR, R and DONE)
- rend_o  out  1  one-cycle pulse: line_o valid
- line_o  out  256  assembled line, word i at [32i+31:32i]
- err_o  out  1  pulses with rend_o if any beat had rresp != 0
- arid_o  out  4  AXI_ID
- araddr_o  out  32  read address
- arlen_o  out  8  burst length - 1
- arsize_o  out  3  always 3'b010
- arburst_o  out  2  always 2'b01 (INCR)
- arvalid_o  out  1  address valid
- arready_i  in  1  address ready
- rdata_i  in  32  read data
- rresp_i  in  2  read response
- rlast_i  in  1  last beat
- rvalid_i  in  1  data valid
- rready_o  out  1  data ready

Behaviour:
- States: IDLE, AR, R, DONE. Reset (asynchronous, rst_n low) forces:
  - state = IDLE
  - beat counter = 0
  - line register = 0
  - rend_o = 0, err_o = 0, arvalid_o = 0, rready_o = 0, busy_o = 0
  - araddr_o = 0, arlen_o = 0
- IDLE:
  - req_i = 1 latches paddr_i and cached_i, clears the beat counter, the line register and the error flag, then moves to AR on the next edge.
  - req_i = 0 stays in IDLE.
- AR:
  - arvalid_o = 1. araddr_o and arlen_o are held stable until the handshake.
  - Cached: araddr_o = {paddr[31:5], 5'b0}, arlen_o = 7.
  - Uncached: araddr_o = paddr, arlen_o = 0.
  - arvalid_o & arready_i moves to R on the next edge; arvalid_o drops in the same edge.
- R:
  - rready_o = 1. Each rvalid_i beat is written into line slot cnt, and cnt increments (3-bit, wraps).
  - Uncached: the single beat is written to slot paddr[4:2] instead of slot cnt; the other slots stay 0.
  - Any rresp_i != 2'b00 on an accepted beat sets the sticky error flag.
  - A beat with rlast_i = 1 is written, then the FSM moves to DONE. rlast_i, not the count, terminates the transaction.
  - More than 8 beats without rlast_i: cnt wraps and earlier slots are overwritten. This is a protocol violation and needs no other handling.
- DONE (one cycle):
  - rend_o = 1; err_o = error flag; line_o holds the assembled line.
  - Next edge returns to IDLE.
  - line_o keeps its value after DONE until the next request's IDLE accept.
- req_i is ignored while busy_o = 1.
- A req_i held high through DONE is accepted in the IDLE cycle that follows, so back-to-back requests have one idle cycle of spacing.
- Latency (no AXI wait states): req accept -> arvalid_o = 1 cycle; cached line -> rend_o at 1 + 1 + 8 + 1 = 11 cycles after req_i is sampled.
- rready_o is 0 outside R. Beats arriving in IDLE, AR or DONE are not accepted.
- Reset mid-transaction aborts immediately; a beat in flight on the bus is dropped. System-level reset covers the slave.

Test Plan:
- Cached refill, paddr = 0x1FC0_0024, arready same cycle, 8 back-to-back beats 0x1000..0x1007 with rlast on the 8th:
  - araddr_o = 0x1FC0_0020, arlen_o = 7, arburst_o = 01.
  - rend_o is a single pulse 11 cycles after req, with line_o[31:0] = 0x1000 and line_o[255:224] = 0x1007; err_o = 0.
- Uncached fetch, paddr = 0xBFC0_0008, one beat 0xDEADBEEF with rlast:
  - araddr_o = 0xBFC0_0008, arlen_o = 0.
  - line_o[95:64] = 0xDEADBEEF and all other words are 0.
- Backpressure: arready held low 5 cycles, then rvalid toggling every other cycle:
  - araddr_o and arvalid_o are stable until the handshake.
  - All 8 words land in the correct slots; rend_o fires exactly once.
- Error response: rresp = 2'b10 on beat 3 of a cached burst -> err_o = 1 coincident with rend_o; busy_o returns to 0.
- Back-to-back: req_i held high across two misses -> second arvalid_o rises 2 cycles after the first rend_o; the second line contains no words from the first line.
- Async reset: assert rst_n low mid-burst (state R, cnt = 4), between clock edges:
  - rready_o, busy_o and arvalid_o fall immediately.
  - After release, the FSM is in IDLE and rend_o is not pulsed.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - I-cache miss/refill sequencer: one AXI INCR line burst or single uncached beat
// Assembles returned beats into a full line and pulses rend_o with it.
module icache_refill_ctrl #(
    parameter logic [3:0] AXI_ID    = 4'd0,
    parameter int         BLOCK_NUM = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_i,
    input  logic                    cached_i,
    input  logic [31:0]             paddr_i,
    output logic                    busy_o,
    output logic                    rend_o,
    output logic [32*BLOCK_NUM-1:0] line_o,
    output logic                    err_o,
    output logic [3:0]              arid_o,
    output logic [31:0]             araddr_o,
    output logic [7:0]              arlen_o,
    output logic [2:0]              arsize_o,
    output logic [1:0]              arburst_o,
    output logic                    arvalid_o,
    input  logic                    arready_i,
    input  logic [31:0]             rdata_i,
    input  logic [1:0]              rresp_i,
    input  logic                    rlast_i,
    input  logic                    rvalid_i,
    output logic                    rready_o
);

    localparam int CW = $clog2(BLOCK_NUM);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_e;

    state_e                       state_q;
    logic [CW-1:0]                cnt_q;
    logic [CW-1:0]                uc_slot_q;
    logic                         cached_q;
    logic                         err_q;
    logic [BLOCK_NUM-1:0][31:0]   line_q;
    logic                         rend_q;
    logic                         err_o_q;
    logic                         arvalid_q;
    logic                         rready_q;
    logic                         busy_q;
    logic [31:0]                  araddr_q;
    logic [7:0]                   arlen_q;

    logic [CW-1:0]                slot_d;
    logic                         beat_err_d;

    // An uncached word lands in its natural slot so the line layout matches a refill.
    assign slot_d     = cached_q ? cnt_q : uc_slot_q;
    assign beat_err_d = |rresp_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            uc_slot_q <= '0;
            cached_q  <= 1'b0;
            err_q     <= 1'b0;
            line_q    <= '0;
            rend_q    <= 1'b0;
            err_o_q   <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
        end else begin
            rend_q  <= 1'b0;
            err_o_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_i) begin
                        cached_q  <= cached_i;
                        uc_slot_q <= paddr_i[CW+1:2];
                        cnt_q     <= '0;
                        line_q    <= '0;
                        err_q     <= 1'b0;
                        arvalid_q <= 1'b1;
                        busy_q    <= 1'b1;
                        if (cached_i) begin
                            araddr_q <= {paddr_i[31:CW+2], {(CW+2){1'b0}}};
                            arlen_q  <= 8'(BLOCK_NUM - 1);
                        end else begin
                            araddr_q <= paddr_i;
                            arlen_q  <= 8'd0;
                        end
                        state_q <= S_AR;
                    end
                end
                S_AR: begin
                    if (arready_i) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid_i) begin
                        line_q[slot_d] <= rdata_i;
                        cnt_q          <= cnt_q + 1'b1;
                        if (beat_err_d) begin
                            err_q <= 1'b1;
                        end
                        // rlast alone ends the burst; the beat count is never consulted.
                        if (rlast_i) begin
                            rready_q <= 1'b0;
                            rend_q   <= 1'b1;
                            err_o_q  <= err_q | beat_err_d;
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign rend_o    = rend_q;
    assign line_o    = line_q;
    assign err_o     = err_o_q;
    assign arid_o    = AXI_ID;
    assign araddr_o  = araddr_q;
    assign arlen_o   = arlen_q;
    assign arsize_o  = 3'b010;
    assign arburst_o = 2'b01;
    assign arvalid_o = arvalid_q;
    assign rready_o  = rready_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - directed self-checking bench for icache_refill_ctrl
module tb_icache_refill_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_i;
    logic         cached_i;
    logic [31:0]  paddr_i;
    logic         busy_o;
    logic         rend_o;
    logic [255:0] line_o;
    logic         err_o;
    logic [3:0]   arid_o;
    logic [31:0]  araddr_o;
    logic [7:0]   arlen_o;
    logic [2:0]   arsize_o;
    logic [1:0]   arburst_o;
    logic         arvalid_o;
    logic         arready_i;
    logic [31:0]  rdata_i;
    logic [1:0]   rresp_i;
    logic         rlast_i;
    logic         rvalid_i;
    logic         rready_o;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    int           rend_cnt = 0;
    int           rend_cyc = 0;
    logic [255:0] rend_line = '0;
    logic         rend_err  = 1'b0;
    int           ar_rise_cyc = 0;
    logic         arv_prev  = 1'b0;

    always #5 clk = ~clk;

    icache_refill_ctrl #(.AXI_ID(4'd0), .BLOCK_NUM(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .cached_i  (cached_i),
        .paddr_i   (paddr_i),
        .busy_o    (busy_o),
        .rend_o    (rend_o),
        .line_o    (line_o),
        .err_o     (err_o),
        .arid_o    (arid_o),
        .araddr_o  (araddr_o),
        .arlen_o   (arlen_o),
        .arsize_o  (arsize_o),
        .arburst_o (arburst_o),
        .arvalid_o (arvalid_o),
        .arready_i (arready_i),
        .rdata_i   (rdata_i),
        .rresp_i   (rresp_i),
        .rlast_i   (rlast_i),
        .rvalid_i  (rvalid_i),
        .rready_o  (rready_o)
    );

    // Advance one clock, sample just after the edge and record rend/arvalid events.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rend_o === 1'b1) begin
            rend_cnt++;
            rend_cyc  = cyc;
            rend_line = line_o;
            rend_err  = err_o;
        end
        if (arvalid_o === 1'b1 && arv_prev !== 1'b1) begin
            ar_rise_cyc = cyc;
        end
        arv_prev = arvalid_o;
    endtask

    task automatic do_beats(input logic [31:0] base, input int n, input int gap,
                            input int err_idx, input bit with_last);
        for (int i = 0; i < n; i++) begin
            int guard;
            guard = 0;
            while (rready_o !== 1'b1 && guard < 20) begin
                rvalid_i = 1'b0;
                tick();
                guard++;
            end
            if (guard >= 20) begin
                n_checks++;
                n_fail++;
                $display("FAIL rready_timeout: rready_o=%b required 1", rready_o);
            end
            rvalid_i = 1'b1;
            rdata_i  = base + 32'(i);
            rresp_i  = (i == err_idx) ? 2'b10 : 2'b00;
            rlast_i  = with_last && (i == n - 1);
            tick();
            if (gap > 0) begin
                rvalid_i = 1'b0;
                rlast_i  = 1'b0;
                rresp_i  = 2'b00;
                rdata_i  = 32'hBAD0_0000;
                repeat (gap) tick();
            end
        end
        if (with_last) begin
            rvalid_i = 1'b0;
            rlast_i  = 1'b0;
            rresp_i  = 2'b00;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_i = 1'b0; cached_i = 1'b0; paddr_i = '0;
        arready_i = 1'b0; rdata_i = '0; rresp_i = '0; rlast_i = 1'b0; rvalid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy_o, rend_o, err_o, arvalid_o, rready_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 00000", {busy_o, rend_o, err_o, arvalid_o, rready_o});
        end
        n_checks++;
        if (araddr_o !== 32'h0 || arlen_o !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_ar: araddr=%h arlen=%h required 0/0", araddr_o, arlen_o);
        end
        n_checks++;
        if (line_o !== 256'h0) begin
            n_fail++;
            $display("FAIL reset_line: got %h required 0", line_o);
        end
        #2 rst_n = 1'b1;
        tick();
        n_checks++;
        if (busy_o !== 1'b0 || arvalid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b arvalid=%b required 0/0", busy_o, arvalid_o);
        end
    endtask

    task automatic test_cached();
        int rc;
        rc = rend_cnt;
        paddr_i = 32'h1FC0_0024; cached_i = 1'b1; arready_i = 1'b1; req_i = 1'b1;
        cyc = 1;
        tick();
        req_i = 1'b0;
        n_checks++;
        if (arvalid_o !== 1'b1 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL cached_arvalid: arvalid=%b busy=%b required 1/1", arvalid_o, busy_o);
        end
        n_checks++;
        if (araddr_o !== 32'h1FC0_0020) begin
            n_fail++;
            $display("FAIL cached_araddr: got %h required 1fc00020", araddr_o);
        end
        n_checks++;
        if (arlen_o !== 8'd7 || arburst_o !== 2'b01 || arsize_o !== 3'b010 || arid_o !== 4'd0) begin
            n_fail++;
            $display("FAIL cached_arattr: len=%0d burst=%b size=%b id=%0d required 7/01/010/0",
                     arlen_o, arburst_o, arsize_o, arid_o);
        end
        tick();
        n_checks++;
        if (arvalid_o !== 1'b0 || rready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL cached_handshake: arvalid=%b rready=%b required 0/1", arvalid_o, rready_o);
        end
        do_beats(32'h0000_1000, 8, 0, -1, 1'b1);
        repeat (3) tick();
        n_checks++;
        if (rend_cnt - rc !== 1) begin
            n_fail++;
            $display("FAIL cached_rend_count: got %0d required 1", rend_cnt - rc);
        end
        n_checks++;
        if (rend_cyc !== 11) begin
            n_fail++;
            $display("FAIL cached_latency: rend in cycle %0d required 11", rend_cyc);
        end
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (rend_line[32*k +: 32] !== 32'h1000 + 32'(k)) begin
                n_fail++;
                $display("FAIL cached_word%0d: got %h required %h", k, rend_line[32*k +: 32], 32'h1000 + 32'(k));
            end
        end
        n_checks++;
        if (rend_err !== 1'b0) begin
            n_fail++;
            $display("FAIL cached_err: got %b required 0", rend_err);
        end
        n_checks++;
        if (line_o[31:0] !== 32'h1000 || line_o[255:224] !== 32'h1007 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL cached_hold: w0=%h w7=%h busy=%b required 1000/1007/0",
                     line_o[31:0], line_o[255:224], busy_o);
        end
    endtask

    task automatic test_uncached();
        paddr_i = 32'hBFC0_0008; cached_i = 1'b0; arready_i = 1'b1; req_i = 1'b1;
        tick();
        req_i = 1'b0;
        n_checks++;
        if (araddr_o !== 32'hBFC0_0008 || arlen_o !== 8'd0) begin
            n_fail++;
            $display("FAIL uncached_ar: araddr=%h arlen=%0d required bfc00008/0", araddr_o, arlen_o);
        end
        tick();
        do_beats(32'hDEAD_BEEF, 1, 0, -1, 1'b1);
        tick();
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (rend_line[32*k +: 32] !== ((k == 2) ? 32'hDEAD_BEEF : 32'h0)) begin
                n_fail++;
                $display("FAIL uncached_word%0d: got %h required %h", k, rend_line[32*k +: 32],
                         (k == 2) ? 32'hDEAD_BEEF : 32'h0);
            end
        end
    endtask

    task automatic test_backpressure();
        int rc;
        rc = rend_cnt;
        paddr_i = 32'h0000_0100; cached_i = 1'b1; arready_i = 1'b0; req_i = 1'b1;
        tick();
        req_i = 1'b0;
        paddr_i = 32'hFFFF_FFFF;
        rvalid_i = 1'b1; rdata_i = 32'hBAD0_0001; rlast_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (arvalid_o !== 1'b1 || araddr_o !== 32'h0000_0100 || arlen_o !== 8'd7) begin
                n_fail++;
                $display("FAIL bp_ar_stable%0d: arvalid=%b araddr=%h arlen=%0d required 1/00000100/7",
                         i, arvalid_o, araddr_o, arlen_o);
            end
            tick();
        end
        arready_i = 1'b1;
        tick();
        n_checks++;
        if (arvalid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_arvalid_drop: got %b required 0", arvalid_o);
        end
        do_beats(32'h0000_5000, 8, 1, -1, 1'b1);
        repeat (3) tick();
        n_checks++;
        if (rend_cnt - rc !== 1) begin
            n_fail++;
            $display("FAIL bp_rend_count: got %0d required 1", rend_cnt - rc);
        end
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (rend_line[32*k +: 32] !== 32'h5000 + 32'(k)) begin
                n_fail++;
                $display("FAIL bp_word%0d: got %h required %h", k, rend_line[32*k +: 32], 32'h5000 + 32'(k));
            end
        end
    endtask

    task automatic test_error();
        paddr_i = 32'h0000_2040; cached_i = 1'b1; arready_i = 1'b1; req_i = 1'b1;
        tick();
        req_i = 1'b0;
        tick();
        do_beats(32'h0000_4000, 8, 0, 3, 1'b1);
        n_checks++;
        if (rend_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_with_rend: got %b required 1", rend_err);
        end
        tick();
        n_checks++;
        if (err_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL err_after: err=%b busy=%b required 0/0", err_o, busy_o);
        end
    endtask

    task automatic test_back_to_back();
        int first_rend;
        paddr_i = 32'h0000_3000; cached_i = 1'b1; arready_i = 1'b1; req_i = 1'b1;
        tick();
        tick();
        do_beats(32'h0000_2000, 8, 0, -1, 1'b1);
        first_rend = rend_cyc;
        paddr_i = 32'h0000_0014; cached_i = 1'b0;
        tick();
        tick();
        req_i = 1'b0;
        n_checks++;
        if (ar_rise_cyc - first_rend !== 2) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles required 2", ar_rise_cyc - first_rend);
        end
        n_checks++;
        if (araddr_o !== 32'h0000_0014 || arlen_o !== 8'd0) begin
            n_fail++;
            $display("FAIL b2b_ar: araddr=%h arlen=%0d required 00000014/0", araddr_o, arlen_o);
        end
        tick();
        do_beats(32'hCAFE_0001, 1, 0, -1, 1'b1);
        tick();
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (rend_line[32*k +: 32] !== ((k == 5) ? 32'hCAFE_0001 : 32'h0)) begin
                n_fail++;
                $display("FAIL b2b_word%0d: got %h required %h", k, rend_line[32*k +: 32],
                         (k == 5) ? 32'hCAFE_0001 : 32'h0);
            end
        end
    endtask

    task automatic test_async_reset();
        int rc;
        rc = rend_cnt;
        paddr_i = 32'h0000_6000; cached_i = 1'b1; arready_i = 1'b1; req_i = 1'b1;
        tick();
        req_i = 1'b0;
        tick();
        do_beats(32'h0000_7000, 4, 0, -1, 1'b0);
        rdata_i = 32'h0000_7004;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (rready_o !== 1'b0 || busy_o !== 1'b0 || arvalid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_immediate: rready=%b busy=%b arvalid=%b required 0/0/0",
                     rready_o, busy_o, arvalid_o);
        end
        n_checks++;
        if (line_o !== 256'h0) begin
            n_fail++;
            $display("FAIL arst_line: got %h required 0", line_o);
        end
        #2 rst_n = 1'b1;
        rvalid_i = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (rend_cnt !== rc || busy_o !== 1'b0 || rready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_quiet: rend_pulses=%0d busy=%b rready=%b required 0/0/0",
                     rend_cnt - rc, busy_o, rready_o);
        end
        paddr_i = 32'h0000_8004; cached_i = 1'b1; req_i = 1'b1;
        tick();
        req_i = 1'b0;
        n_checks++;
        if (arvalid_o !== 1'b1 || araddr_o !== 32'h0000_8000) begin
            n_fail++;
            $display("FAIL arst_idle_accept: arvalid=%b araddr=%h required 1/00008000", arvalid_o, araddr_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cached();
        test_uncached();
        test_backpressure();
        test_error();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
